// File: rtl/ahb_region_dphase.sv
// AHB-Lite data-phase region steering. Registers the decoder select on
// each accepted address phase, muxes the selected slave's response back to
// the master, and generates the two-cycle ERROR response for unmapped
// accesses and for slaves that stall past the timeout.
module ahb_region_dphase #(
  parameter int XLEN           = 64,
  parameter int NREGIONS       = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NREGIONS-1:0]                SelRegions,
  input  logic [1:0]                         HTRANS,
  input  logic [NREGIONS-2:0]                HREADYRegions,
  input  logic [NREGIONS-2:0]                HRESPRegions,
  input  logic [NREGIONS-1:1][XLEN-1:0]      HRDATARegions,
  output logic [NREGIONS-1:0]                HSELRegionsD,
  output logic                               HREADY,
  output logic                               HRESP,
  output logic [XLEN-1:0]                    HRDATA,
  output logic                               TimeoutErr
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value seen on the last tolerated stall edge; that edge moves to ERR1.
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [NREGIONS-1:0] sel_next;
  logic [CW-1:0]       stall_cnt, stall_next;
  logic                timeout_next;
  logic                take_addr;

  logic                s_ready;
  logic                s_resp;
  logic [XLEN-1:0]     s_data;

  // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  logic                htrans_unused;
  assign htrans_unused = HTRANS[0];

  // Steer the lowest-numbered selected slave (bit 0 is never a slave).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s_ready = 1'b1;
    s_resp  = 1'b0;
    s_data  = '0;
    for (int i = NREGIONS - 1; i >= 1; i--) begin
      if (HSELRegionsD[i]) begin
        s_ready = HREADYRegions[i-1];
        s_resp  = HRESPRegions[i-1];
        s_data  = HRDATARegions[i];
      end
    end
  end

  // Next-state, bus outputs and address-phase capture.
  always_comb begin
    state_next   = state;
    sel_next     = HSELRegionsD;
    stall_next   = '0;
    timeout_next = 1'b0;
    take_addr    = 1'b0;
    HREADY       = 1'b1;
    HRESP        = 1'b0;
    HRDATA       = '0;

    unique case (state)
      IDLE: take_addr = 1'b1;
      DATA: begin
        HREADY = s_ready;
        HRESP  = s_resp;
        HRDATA = s_data;
        if (s_ready) begin
          take_addr = 1'b1;
        end else if (stall_cnt == STALL_LAST) begin
          state_next   = ERR1;
          timeout_next = 1'b1;
        end else if (stall_cnt != '1) begin
          stall_next = stall_cnt + 1'b1;
        end else begin
          stall_next = stall_cnt;
        end
      end
      ERR1: begin
        HREADY     = 1'b0;
        HRESP      = 1'b1;
        state_next = ERR2;
      end
      ERR2: begin
        HRESP     = 1'b1;
        take_addr = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Accept rule: every HREADY=1 cycle either captures a new address phase or idles.
    if (take_addr) begin
      if (HTRANS[1]) begin
        sel_next   = SelRegions;
        state_next = SelRegions[0] ? ERR1 : DATA;
      end else begin
        sel_next   = '0;
        state_next = IDLE;
      end
    end
  end

  // State, select, stall counter and timeout pulse registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      HSELRegionsD <= '0;
      stall_cnt    <= '0;
      TimeoutErr   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state        <= state_next;
      HSELRegionsD <= sel_next;
      stall_cnt    <= stall_next;
      TimeoutErr   <= timeout_next;
    end
  end

endmodule
